// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-line, read-only instruction cache between fetch and the memory instruction port.
// Hits are served combinationally; a miss runs a single-outstanding fill and the request then hits on re-evaluation.
module icache_dm #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state, state_nxt;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  // Word address of the outstanding miss; the byte offset is always zero.
  logic [29:0]      miss_word;

  logic [IDX-1:0]   req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             hit, fill, start;
  logic             unused_bits;

  assign req_idx     = imemaddr[IDX+1:2];
  assign req_tag     = imemaddr[31:IDX+2];
  assign miss_idx    = miss_word[IDX-1:0];
  assign miss_tag    = miss_word[29:IDX];
  assign unused_bits = ^imemaddr[1:0];

  assign hit   = imemREN & valid[req_idx] & (tags[req_idx] == req_tag) & (state == IDLE) & ~flush;
  assign start = (state == IDLE) & imemREN & ~hit & ~flush;
  // Flush beats a completing response: the fill is dropped.
  assign fill  = (state == FETCH) & ~iwait & ~flush;

  assign ihit     = hit;
  assign imemload = hit ? data[req_idx] : 32'h0;

  always_comb begin
    state_nxt = state;
    iREN      = 1'b0;
    iaddr     = 32'h0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = {miss_word, 2'b00};
        if (flush || !iwait) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_word <= '0;
      valid     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start) miss_word <= imemaddr[31:2];
      if (flush)     valid           <= '0;
      else if (fill) valid[miss_idx] <= 1'b1;
      if (hit)  hit_cnt  <= hit_cnt + CNT_W'(1);
      if (fill) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  // Tag and data need no reset: the valid bit qualifies them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[miss_idx] <= miss_tag;
      data[miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: fills, hits, conflicts, flushes, idle requests and reset mid-fill.
module tb_icache_dm;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_cnt, miss_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  icache_dm #(.SETS(16), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .flush(flush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven just after the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic fill(input logic [31:0] addr, input logic [31:0] word, input int lat);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    #1;
    chk("miss_ihit", {31'b0, ihit}, 32'h0);
    chk("miss_iren_idle", {31'b0, iREN}, 32'h0);
    tick();
    for (int k = 0; k <= lat; k++) begin
      iwait = (k < lat); iload = word;
      #1;
      chk("fetch_iren", {31'b0, iREN}, 32'h1);
      chk("fetch_iaddr", iaddr, {addr[31:2], 2'b00});
      chk("fetch_ihit", {31'b0, ihit}, 32'h0);
      tick();
    end
    exp_miss++;
    iwait = 1'b1;
    #1;
    chk("fill_ihit", {31'b0, ihit}, 32'h1);
    chk("fill_data", imemload, word);
    chk("fill_iren", {31'b0, iREN}, 32'h0);
    chk("fill_miss_cnt", miss_cnt, exp_miss);
    imemREN = 1'b0;
  endtask

  task automatic hit_cyc(input logic [31:0] addr, input logic [31:0] word);
    imemREN = 1'b1; imemaddr = addr;
    #1;
    chk("hit_ihit", {31'b0, ihit}, 32'h1);
    chk("hit_data", imemload, word);
    chk("hit_iren", {31'b0, iREN}, 32'h0);
    tick();
    exp_hit++;
    imemREN = 1'b0;
    #1;
    chk("hit_cnt", hit_cnt, exp_hit);
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; flush = 1'b0;
    iwait = 1'b1; iload = '0;
    @(negedge CLK); #1;
    chk("rst_ihit", {31'b0, ihit}, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iren", {31'b0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_hit_cnt", hit_cnt, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
    @(negedge CLK); #1;
    nRST = 1'b1;
    tick();

    // First miss: 3 wait cycles then data, iREN held 4 cycles
    fill(32'h0000_0000, 32'h2408_0001, 3);
    hit_cyc(32'h0000_0000, 32'h2408_0001);
    hit_cyc(32'h0000_0000, 32'h2408_0001);
    hit_cyc(32'h0000_0000, 32'h2408_0001);
    chk("hits_total", hit_cnt, 32'd3);

    // Conflict on index 1
    fill(32'h0000_0004, 32'hAAAA_AAAA, 1);
    fill(32'h0000_0044, 32'hBBBB_BBBB, 0);
    hit_cyc(32'h0000_0044, 32'hBBBB_BBBB);
    imemREN = 1'b1; imemaddr = 32'h0000_0004;
    #1;
    chk("evict_ihit", {31'b0, ihit}, 32'h0);
    chk("evict_miss_cnt", miss_cnt, 32'd3);
    tick();
    chk("evict_iren", {31'b0, iREN}, 32'h1);
    chk("evict_iaddr", iaddr, 32'h0000_0004);
    iwait = 1'b0; iload = 32'hAAAA_AAAA;
    tick();
    exp_miss++;
    iwait = 1'b1;
    #1;
    chk("refill_data", imemload, 32'hAAAA_AAAA);
    imemREN = 1'b0;
    tick();

    // Flush while waiting on memory
    imemREN = 1'b1; imemaddr = 32'h0000_0010;
    tick();
    chk("fl_fetch_iren", {31'b0, iREN}, 32'h1);
    flush = 1'b1;
    #1;
    chk("fl_ihit", {31'b0, ihit}, 32'h0);
    tick();
    flush = 1'b0; imemREN = 1'b0;
    #1;
    chk("fl_iren", {31'b0, iREN}, 32'h0);
    chk("fl_iaddr", iaddr, 32'h0);
    chk("fl_miss_cnt", miss_cnt, exp_miss);
    imemREN = 1'b1; imemaddr = 32'h0000_0000;
    #1;
    chk("fl_line0_miss", {31'b0, ihit}, 32'h0);
    imemREN = 1'b0;
    tick();

    // Flush coincident with the memory response
    imemREN = 1'b1; imemaddr = 32'h0000_0020;
    tick();
    iwait = 1'b0; iload = 32'h1234_5678; flush = 1'b1;
    tick();
    flush = 1'b0; iwait = 1'b1;
    #1;
    chk("flr_iren", {31'b0, iREN}, 32'h0);
    chk("flr_miss_cnt", miss_cnt, exp_miss);
    chk("flr_ihit", {31'b0, ihit}, 32'h0);
    tick();
    chk("flr_reissue", {31'b0, iREN}, 32'h1);
    chk("flr_reissue_addr", iaddr, 32'h0000_0020);
    iwait = 1'b0;
    tick();
    exp_miss++;
    iwait = 1'b1;
    #1;
    chk("flr_fill_data", imemload, 32'h1234_5678);
    imemREN = 1'b0;
    tick();

    // Idle requests leave everything alone
    imemaddr = 32'h0000_0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_ihit", {31'b0, ihit}, 32'h0);
      chk("idle_imemload", imemload, 32'h0);
      chk("idle_iren", {31'b0, iREN}, 32'h0);
      chk("idle_hit_cnt", hit_cnt, exp_hit);
      chk("idle_miss_cnt", miss_cnt, exp_miss);
      tick();
    end

    // Asynchronous reset during a fill
    hit_cyc(32'h0000_0020, 32'h1234_5678);
    imemREN = 1'b1; imemaddr = 32'h0000_0008;
    tick();
    chk("rf_iren", {31'b0, iREN}, 32'h1);
    nRST = 1'b0;
    #1;
    chk("rf_iren_drop", {31'b0, iREN}, 32'h0);
    chk("rf_hit_cnt", hit_cnt, 32'h0);
    chk("rf_miss_cnt", miss_cnt, 32'h0);
    iwait = 1'b0; iload = 32'hDEAD_BEEF;
    imemREN = 1'b0;
    tick();
    iwait = 1'b1;
    nRST = 1'b1;
    imemREN = 1'b1; imemaddr = 32'h0000_0020;
    #1;
    chk("rf_old_line_miss", {31'b0, ihit}, 32'h0);
    imemREN = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
